// File: rtl/mux_rr_stream_pkg.sv
// Shared constants and the cyclic round-robin pick used by mux_rr_stream.
// MUX_RR_STREAM_LAST_LOCK_EN (optional) uses lock_state_t for packet locking.
package mux_rr_stream_pkg;

    localparam int   MAX_N      = 16;
    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_t;

    // First valid channel found by searching upward from ptr, wrapping at n.
    function automatic logic [MAX_N-1:0] rr_pick(input logic [MAX_N-1:0] valid,
                                                input int ptr, input int n);
        logic [MAX_N-1:0] g;
        int idx;
        g = '0;
        for (int k = 0; k < MAX_N; k++) begin
            idx = (ptr + k) % n;
            if (k < n && g == '0 && valid[idx]) g[idx] = 1'b1;
        end
        return g;
    endfunction

endpackage

// File: rtl/mux_rr_stream_arbiter.sv
// Round-robin arbiter: owns the rotating pointer, reports one-hot and encoded grant.
module rr_arbiter
    import mux_rr_stream_pkg::*;
#(
    parameter  int N    = 4,
    localparam int CH_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    valid,
    input  logic            advance,
    input  logic [CH_W-1:0] done_idx,
    output logic [N-1:0]    grant,
    output logic [CH_W-1:0] grant_idx,
    output logic [CH_W-1:0] ptr
);

    logic [MAX_N-1:0] pick;
    logic             unused_pick;

    always_comb begin
        pick      = rr_pick(MAX_N'(valid), int'(ptr), N);
        grant     = pick[N-1:0];
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) grant_idx = CH_W'(i);
        end
    end

    // Upper pick bits are always zero when N < MAX_N.
    assign unused_pick = ^pick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (done_idx == CH_W'(N - 1)) ? '0 : done_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mux_rr_stream.sv
// N-way valid/ready stream merge with registered output, round-robin or fixed select.
// Optional MUX_RR_STREAM_LAST_LOCK_EN adds in_last/out_last and locks grant for a packet.
module mux_rr_stream
    import mux_rr_stream_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 8,
    localparam int CH_W = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0][W-1:0] in_data,
    input  logic [N-1:0]        in_valid,
    output logic [N-1:0]        in_ready,
    input  logic                sel_mode,
    input  logic [CH_W-1:0]     fixed_sel,
    output logic [W-1:0]        out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH_W-1:0]     out_ch
`ifdef MUX_RR_STREAM_LAST_LOCK_EN
    ,
    input  logic [N-1:0]        in_last,
    output logic                out_last
`endif
);

    typedef logic [CH_W-1:0] ch_idx_t;

    logic     can_load;
    logic     xfer;
    logic     advance;
    logic     sel_hit;
    logic     fixed_ok;
    ch_idx_t  sel_idx;
    ch_idx_t  rr_idx;
    ch_idx_t  ptr;
    logic [N-1:0] rr_grant;

    assign can_load = !out_valid || out_ready;
    assign xfer     = |in_ready;

    // fixed_sel can only exceed N-1 when N is not a power of two.
    if ((1 << CH_W) > N) begin : g_range
        assign fixed_ok = fixed_sel < CH_W'(N);
    end else begin : g_full
        assign fixed_ok = 1'b1;
    end

`ifdef MUX_RR_STREAM_LAST_LOCK_EN
    lock_state_t lock_state;
    ch_idx_t     lock_ch;
    logic        lock_rr;
    logic        locked;

    assign locked  = (lock_state == ST_LOCKED);
    assign advance = xfer && in_last[sel_idx] && (locked ? lock_rr : (sel_mode == MODE_RR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_state <= ST_OPEN;
            lock_ch    <= '0;
            lock_rr    <= 1'b0;
        end else begin
            case (lock_state)
                ST_OPEN: if (xfer && !in_last[sel_idx]) begin
                    lock_state <= ST_LOCKED;
                    lock_ch    <= sel_idx;
                    lock_rr    <= (sel_mode == MODE_RR);
                end
                ST_LOCKED: if (xfer && in_last[sel_idx]) lock_state <= ST_OPEN;
                default: lock_state <= ST_OPEN;
            endcase
        end
    end
`else
    assign advance = xfer && (sel_mode == MODE_RR);
`endif

    rr_arbiter #(.N(N)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid     (in_valid),
        .advance   (advance),
        .done_idx  (sel_idx),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .ptr       (ptr)
    );

    always_comb begin
        sel_idx = rr_idx;
        sel_hit = |rr_grant;
`ifdef MUX_RR_STREAM_LAST_LOCK_EN
        if (locked) begin
            sel_idx = lock_ch;
            sel_hit = in_valid[lock_ch];
        end else
`endif
        if (sel_mode == MODE_FIXED) begin
            sel_idx = fixed_sel;
            sel_hit = fixed_ok && in_valid[fixed_sel];
        end
        for (int i = 0; i < N; i++) begin
            in_ready[i] = !rst && can_load && sel_hit && (sel_idx == CH_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
`ifdef MUX_RR_STREAM_LAST_LOCK_EN
            out_last  <= 1'b0;
`endif
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[sel_idx];
            out_ch    <= sel_idx;
`ifdef MUX_RR_STREAM_LAST_LOCK_EN
            out_last  <= in_last[sel_idx];
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_stream.sv
// Randomised and directed checks of mux_rr_stream against a behavioural scoreboard model.
module tb_mux_rr_stream;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int CH_W = 2;
    localparam int EW   = 1 + CH_W + W;

    logic                clk;
    logic                rst;
    logic [N-1:0][W-1:0] in_data;
    logic [N-1:0]        in_valid;
    logic [N-1:0]        in_ready;
    logic                sel_mode;
    logic [CH_W-1:0]     fixed_sel;
    logic [W-1:0]        out_data;
    logic                out_valid;
    logic                out_ready;
    logic [CH_W-1:0]     out_ch;
    logic [N-1:0]        in_last;

    logic [4:0][W-1:0]   d5_in_data;
    logic [4:0]          d5_in_valid;
    logic [4:0]          d5_in_ready;
    logic                d5_sel_mode;
    logic [2:0]          d5_fixed_sel;
    logic [W-1:0]        d5_out_data;
    logic                d5_out_valid;
    logic                d5_out_ready;
    logic [2:0]          d5_out_ch;
    logic [4:0]          d5_in_last;

`ifdef MUX_RR_STREAM_LAST_LOCK_EN
    logic                out_last;
    logic                d5_out_last;
`endif

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_q[$];
    int   m_ptr;
    logic m_valid;
    logic m_locked;
    int   m_lock_ch;
    logic m_lock_rr;

    mux_rr_stream #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sel_mode(sel_mode), .fixed_sel(fixed_sel), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_ch(out_ch)
`ifdef MUX_RR_STREAM_LAST_LOCK_EN
        , .in_last(in_last), .out_last(out_last)
`endif
    );

    mux_rr_stream #(.N(5), .W(W)) dut5 (
        .clk(clk), .rst(rst), .in_data(d5_in_data), .in_valid(d5_in_valid), .in_ready(d5_in_ready),
        .sel_mode(d5_sel_mode), .fixed_sel(d5_fixed_sel), .out_data(d5_out_data),
        .out_valid(d5_out_valid), .out_ready(d5_out_ready), .out_ch(d5_out_ch)
`ifdef MUX_RR_STREAM_LAST_LOCK_EN
        , .in_last(d5_in_last), .out_last(d5_out_last)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // reference model: which channel the rules grant this cycle, or -1
    function automatic int model_pick();
        if (m_locked) return in_valid[m_lock_ch] ? m_lock_ch : -1;
        if (sel_mode) return (int'(fixed_sel) < N && in_valid[fixed_sel]) ? int'(fixed_sel) : -1;
        for (int k = 0; k < N; k++) begin
            if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // scoreboard monitor: samples on the falling edge, between driver updates
    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_rdy;
        logic [EW-1:0] e;
        logic lastbit, was_locked, adv;
        if (rst) begin
            m_ptr = 0; m_valid = 1'b0; m_locked = 1'b0; m_lock_ch = 0; m_lock_rr = 1'b0;
            exp_q.delete();
            chk("in_ready_rst", 32'(in_ready), 32'(0));
        end else begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("exp_q_empty", 32'(0), 32'(1));
                end else begin
                    e = exp_q[0];
                    chk("out_data", 32'(out_data), 32'(e[W-1:0]));
                    chk("out_ch", 32'(out_ch), 32'(e[W+CH_W-1:W]));
`ifdef MUX_RR_STREAM_LAST_LOCK_EN
                    chk("out_last", 32'(out_last), 32'(e[EW-1]));
`endif
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            g = model_pick();
            exp_rdy = '0;
            if ((!m_valid || out_ready) && g >= 0) exp_rdy[g] = 1'b1;
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            if (exp_rdy != '0) begin
`ifdef MUX_RR_STREAM_LAST_LOCK_EN
                lastbit = in_last[g];
`else
                lastbit = 1'b1;
`endif
                exp_q.push_back({lastbit, CH_W'(g), in_data[g]});
                was_locked = m_locked;
`ifdef MUX_RR_STREAM_LAST_LOCK_EN
                if (!m_locked && !lastbit) begin
                    m_locked = 1'b1; m_lock_ch = g; m_lock_rr = !sel_mode;
                end
                if (lastbit) m_locked = 1'b0;
                adv = lastbit && (was_locked ? m_lock_rr : !sel_mode);
`else
                adv = !sel_mode && !was_locked;
`endif
                if (adv) m_ptr = (g + 1) % N;
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // driver
    initial begin
        rst = 1'b1; in_data = '0; in_valid = '0; in_last = '1; sel_mode = 1'b0;
        fixed_sel = '0; out_ready = 1'b1;
        d5_in_valid = '0; d5_in_last = '1; d5_sel_mode = 1'b1; d5_fixed_sel = 3'd5;
        d5_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) d5_in_data[i] = W'(8'h10 + i);
        tick(2);
        rst = 1'b0;
        tick(4);

        // fairness: all valid, data = channel id
        for (int i = 0; i < N; i++) in_data[i] = W'(i);
        in_valid = '1;
        tick(10);

        // mid-stream asynchronous reset
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_ch", 32'(out_ch), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        tick(1);
        rst = 1'b0;
        in_valid = '0;
        tick(3);

        // skip and wrap
        in_valid = 4'b1010; tick(4);
        in_valid = 4'b0010; tick(1);
        in_valid = 4'b0001; tick(1);
        in_valid = '0;      tick(2);

        // backpressure holding 0xA5
        in_data[0] = 8'hA5; in_valid = 4'b0001; tick(1);
        out_ready = 1'b0; in_valid = '1;
        for (int i = 0; i < N; i++) in_data[i] = W'($urandom_range(0, 255));
        tick(5);
        out_ready = 1'b1; tick(3);

        // fixed select
        sel_mode = 1'b1; fixed_sel = 2'd2; tick(5);
        fixed_sel = 2'd1; tick(2);
        fixed_sel = 2'd2; in_valid = 4'b1011; tick(3);
        sel_mode = 1'b0; in_valid = '0; tick(2);

`ifdef MUX_RR_STREAM_LAST_LOCK_EN
        // ch0 three-beat packet while ch1 waits
        in_data[0] = 8'h30; in_data[1] = 8'h31;
        in_last = 4'b1110; in_valid = 4'b0001; tick(1);
        in_valid = 4'b0011; tick(1);
        in_last = 4'b1111; tick(1);
        in_valid = 4'b0010; tick(2);
        in_valid = '0; tick(2);
`endif

        // random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) in_data[i] = W'($urandom_range(0, 255));
            in_valid  = N'($urandom_range(0, (1 << N) - 1));
            in_last   = N'($urandom_range(0, (1 << N) - 1));
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) sel_mode = ~sel_mode;
            fixed_sel = CH_W'($urandom_range(0, N - 1));
            tick(1);
        end
        in_last = '1; in_valid = '0; out_ready = 1'b1; sel_mode = 1'b0;
        tick(6);
        chk("drain_queue", 32'(exp_q.size()), 32'(0));

        // out-of-range fixed select on a five-channel instance
        d5_in_valid = '1;
        for (int s = 5; s < 8; s++) begin
            d5_fixed_sel = 3'(s);
            #1;
            chk("d5_oor_ready", 32'(d5_in_ready), 32'(0));
            tick(2);
            chk("d5_oor_valid", 32'(d5_out_valid), 32'(0));
        end
        d5_fixed_sel = 3'd4;
        #1;
        chk("d5_sel4_ready", 32'(d5_in_ready), 32'(5'b10000));
        tick(1);
        chk("d5_sel4_valid", 32'(d5_out_valid), 32'(1));
        chk("d5_sel4_ch", 32'(d5_out_ch), 32'(4));
        chk("d5_sel4_data", 32'(d5_out_data), 32'(8'h14));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
